// File: rtl/stall_gen.sv
// Pipeline stall generator: load-use bubbles and data-memory wait with timeout.
// Latency: stall/stall_cause assert one clock after the hazard or wait is detected.
// Backpressure: none accepted; stall_o is the backpressure this block exerts on the pipeline.
module stall_gen #(
  parameter int unsigned LOAD_LAT    = 1,   // load-use bubble length, 1..7
  parameter int unsigned MEM_TIMEOUT = 15   // max MEM_WAIT cycles, 1..255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_uses_rs1_i,
  input  logic        dec_uses_rs2_i,
  input  logic        exe_valid_i,
  input  logic [4:0]  exe_rd_i,
  input  logic        exe_is_load_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic [1:0]  stall_cause_o,
  output logic        timeout_err_o,
  output logic [15:0] perf_stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LU   = 2'b01;
  localparam logic [1:0] CAUSE_MEM  = 2'b10;

  // Bubble counter starts at LOAD_LAT-1 so LU_STALL lasts exactly LOAD_LAT cycles.
  localparam logic [2:0] BUB_INIT  = 3'(LOAD_LAT - 1);
  // Last wait count before the access is declared timed out.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [2:0]  bub_q;
  logic [7:0]  wait_q;
  logic        stall_q;
  logic [1:0]  cause_q;
  logic        err_q;
  logic [15:0] perf_q;

  logic        rs1_hit;
  logic        rs2_hit;
  logic        hz;
  logic        mw;

  // Hazard and memory-wait detection; x0 never creates a dependency.
  assign rs1_hit = dec_uses_rs1_i && (dec_rs1_i == exe_rd_i);
  assign rs2_hit = dec_uses_rs2_i && (dec_rs2_i == exe_rd_i);
  assign hz = exe_valid_i && exe_is_load_i && (exe_rd_i != 5'd0) &&
              dec_valid_i && (rs1_hit || rs2_hit);
  assign mw = dmem_req_i && !dmem_ack_i;

  // Stall FSM; stall and cause are registered alongside the state so they never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bub_q   <= 3'd0;
      wait_q  <= 8'd0;
      stall_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Memory wait outranks a load-use hazard; a stray ack is ignored.
          if (mw) begin
            state_q <= MEM_WAIT;
            wait_q  <= 8'd0;
            stall_q <= 1'b1;
            cause_q <= CAUSE_MEM;
          end else if (hz) begin
            state_q <= LU_STALL;
            bub_q   <= BUB_INIT;
            stall_q <= 1'b1;
            cause_q <= CAUSE_LU;
          end
        end
        LU_STALL: begin
          if (mw) begin
            state_q <= MEM_WAIT;
            wait_q  <= 8'd0;
            stall_q <= 1'b1;
            cause_q <= CAUSE_MEM;
          end else if (bub_q == 3'd0) begin
            // Return to IDLE without re-checking hz/mw this cycle.
            state_q <= IDLE;
            stall_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else begin
            bub_q <= bub_q - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else if (wait_q == WAIT_LAST) begin
            // Give up on the access; the error flag is sticky until reset.
            state_q <= IDLE;
            stall_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
          cause_q <= CAUSE_NONE;
        end
      endcase
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= 16'd0;
    end else if (stall_q && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign stall_o             = stall_q;
  assign stall_cause_o       = cause_q;
  assign timeout_err_o       = err_q;
  assign perf_stall_cycles_o = perf_q;

endmodule

// File: tb/tb_stall_gen.sv
// Bench for stall_gen: two instances with different latency/timeout settings share stimulus.
// A spec-level model predicts every output each cycle; literal checks pin key points.
// Inputs change 1ns after the rising edge; outputs compared on the falling edge.
module tb_stall_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       dec_valid, dec_uses_rs1, dec_uses_rs2;
  logic [4:0] dec_rs1, dec_rs2, exe_rd;
  logic       exe_valid, exe_is_load, dmem_req, dmem_ack;

  logic        stall_a, err_a, stall_b, err_b;
  logic [1:0]  cause_a, cause_b;
  logic [15:0] perf_a, perf_b;

  stall_gen #(.LOAD_LAT(1), .MEM_TIMEOUT(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_uses_rs1_i(dec_uses_rs1), .dec_uses_rs2_i(dec_uses_rs2),
    .exe_valid_i(exe_valid), .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_o(stall_a), .stall_cause_o(cause_a), .timeout_err_o(err_a),
    .perf_stall_cycles_o(perf_a)
  );

  stall_gen #(.LOAD_LAT(3), .MEM_TIMEOUT(15)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_uses_rs1_i(dec_uses_rs1), .dec_uses_rs2_i(dec_uses_rs2),
    .exe_valid_i(exe_valid), .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .stall_o(stall_b), .stall_cause_o(cause_b), .timeout_err_o(err_b),
    .perf_stall_cycles_o(perf_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 load-use bubble, 2 waiting on memory.
  // left = bubble cycles still to serve; waited = ack-less cycles spent waiting.
  typedef struct {
    int mode;
    int left;
    int waited;
    bit err;
    int perf;
  } mst_t;

  int   LL[2] = '{1, 3};
  int   MT[2] = '{4, 15};
  mst_t m[2];

  function automatic bit hazard();
    bit dep;
    dep = (dec_uses_rs1 && dec_rs1 == exe_rd) || (dec_uses_rs2 && dec_rs2 == exe_rd);
    return exe_valid && exe_is_load && (exe_rd != 0) && dec_valid && dep;
  endfunction

  function automatic mst_t step(mst_t s, int ll, int mt, bit hz, bit mw, bit ack);
    mst_t n;
    n = s;
    if (s.mode != 0 && s.perf < 65535) n.perf = s.perf + 1;
    case (s.mode)
      0: begin
        if (mw) begin n.mode = 2; n.waited = 0; end
        else if (hz) begin n.mode = 1; n.left = ll; end
      end
      1: begin
        if (mw) begin n.mode = 2; n.waited = 0; end
        else begin
          n.left = s.left - 1;
          if (n.left == 0) n.mode = 0;
        end
      end
      default: begin
        if (ack) n.mode = 0;
        else begin
          n.waited = s.waited + 1;
          if (n.waited == mt) begin n.mode = 0; n.err = 1'b1; end
        end
      end
    endcase
    return n;
  endfunction

  function automatic mst_t zero_state();
    mst_t z;
    z.mode = 0; z.left = 0; z.waited = 0; z.err = 1'b0; z.perf = 0;
    return z;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= zero_state();
      m[1] <= zero_state();
    end else begin
      m[0] <= step(m[0], LL[0], MT[0], hazard(), dmem_req && !dmem_ack, dmem_ack);
      m[1] <= step(m[1], LL[1], MT[1], hazard(), dmem_req && !dmem_ack, dmem_ack);
    end
  end

  task automatic cmp(input string tag, input mst_t s, input logic st, input logic [1:0] ca,
                     input logic er, input logic [15:0] pf);
    chk({tag, "_stall"}, 32'(st), 32'(s.mode != 0));
    chk({tag, "_cause"}, 32'(ca), (s.mode == 1) ? 32'd1 : (s.mode == 2) ? 32'd2 : 32'd0);
    chk({tag, "_err"},   32'(er), 32'(s.err));
    chk({tag, "_perf"},  32'(pf), 32'(s.perf));
  endtask

  always @(negedge clk) begin
    cmp("mdl_a", m[0], stall_a, cause_a, err_a, perf_a);
    cmp("mdl_b", m[1], stall_b, cause_b, err_b, perf_b);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
    exe_valid = 0; exe_rd = 0; exe_is_load = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic set_hz(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    exe_valid = 1; exe_is_load = 1; exe_rd = rd;
    dec_valid = 1; dec_rs1 = r1; dec_uses_rs1 = u1; dec_rs2 = r2; dec_uses_rs2 = u2;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #3;
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_cause_a", 32'(cause_a), 32'd0);
    chk("rst_err_a",   32'(err_a),   32'd0);
    chk("rst_perf_a",  32'(perf_a),  32'd0);
    chk("rst_stall_b", 32'(stall_b), 32'd0);
    #10 rst_n = 1'b1;
    tick(); tick();

    // Load-use rd=5 vs rs1=5
    set_hz(5, 5, 1, 0, 0); tick(); clr();
    chk("lu_stall_a", 32'(stall_a), 32'd1);
    chk("lu_cause_a", 32'(cause_a), 32'd1);
    chk("lu_cause_b", 32'(cause_b), 32'd1);
    tick();
    chk("lu_end_a",   32'(stall_a), 32'd0);
    chk("lu_perf_a",  32'(perf_a),  32'd1);
    chk("lu_mid_b",   32'(stall_b), 32'd1);
    tick();
    chk("lu_last_b",  32'(stall_b), 32'd1);
    tick();
    chk("lu_end_b",   32'(stall_b), 32'd0);
    chk("lu_perf_b",  32'(perf_b),  32'd3);

    // x0 destination and unused rs2 never stall; used rs2 does
    set_hz(0, 0, 1, 0, 0); tick(); clr();
    chk("x0_a", 32'(stall_a), 32'd0);
    chk("x0_b", 32'(stall_b), 32'd0);
    set_hz(7, 3, 1, 7, 0); tick(); clr();
    chk("rs2_unused_a", 32'(stall_a), 32'd0);
    set_hz(7, 3, 1, 7, 1); tick(); clr();
    chk("rs2_used_a", 32'(stall_a), 32'd1);
    repeat (3) tick();
    chk("rs2_drain_b", 32'(stall_b), 32'd0);

    // Memory wait: three ack-less cycles then ack -> four stall cycles
    dmem_req = 1; dmem_ack = 0; tick();
    chk("mw_cause_a", 32'(cause_a), 32'd2);
    chk("mw_cause_b", 32'(cause_b), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("mw_hold_a", 32'(stall_a), 32'd1);
      tick();
    end
    dmem_ack = 1;
    chk("mw_last_a", 32'(stall_a), 32'd1);
    tick(); clr();
    chk("mw_done_a", 32'(stall_a), 32'd0);
    chk("mw_err_a",  32'(err_a),   32'd0);
    chk("mw_done_b", 32'(stall_b), 32'd0);

    // Timeout with MEM_TIMEOUT=4 on instance a
    dmem_req = 1; dmem_ack = 0; tick(); dmem_req = 0;
    repeat (3) tick();
    chk("to_pre_stall_a", 32'(stall_a), 32'd1);
    chk("to_pre_err_a",   32'(err_a),   32'd0);
    tick();
    chk("to_stall_a", 32'(stall_a), 32'd0);
    chk("to_err_a",   32'(err_a),   32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("to_sticky_a", 32'(err_a), 32'd1);
    end
    chk("to_err_b", 32'(err_b), 32'd1);

    // hz and mw together: memory wait wins
    set_hz(5, 5, 1, 0, 0); dmem_req = 1; dmem_ack = 0; tick(); clr();
    chk("both_cause_a", 32'(cause_a), 32'd2);
    chk("both_cause_b", 32'(cause_b), 32'd2);
    dmem_ack = 1; tick();
    tick();
    chk("stray_ack_a", 32'(stall_a), 32'd0);
    chk("stray_ack_b", 32'(stall_b), 32'd0);
    clr();

    // LOAD_LAT=3: mw in second bubble cycle switches cause 01 -> 10
    set_hz(9, 0, 0, 9, 1); tick(); clr();
    chk("sw1_cause_b", 32'(cause_b), 32'd1);
    tick();
    chk("sw2_cause_b", 32'(cause_b), 32'd1);
    dmem_req = 1; dmem_ack = 0; tick();
    chk("sw3_cause_b", 32'(cause_b), 32'd2);
    chk("sw3_cause_a", 32'(cause_a), 32'd2);
    dmem_req = 0; dmem_ack = 1; tick(); clr();
    chk("sw_done_b", 32'(stall_b), 32'd0);

    // Asynchronous reset in the middle of a memory wait
    dmem_req = 1; dmem_ack = 0; tick(); dmem_req = 0; tick();
    chk("ar_pre_a", 32'(stall_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stall_a", 32'(stall_a), 32'd0);
    chk("ar_perf_a",  32'(perf_a),  32'd0);
    chk("ar_err_a",   32'(err_a),   32'd0);
    chk("ar_stall_b", 32'(stall_b), 32'd0);
    chk("ar_err_b",   32'(err_b),   32'd0);
    #4 rst_n = 1'b1;
    clr();
    tick();
    chk("ar_idle_a", 32'(stall_a), 32'd0);
    set_hz(5, 5, 1, 0, 0); tick(); clr();
    chk("ar_lu_stall_a", 32'(stall_a), 32'd1);
    chk("ar_lu_cause_a", 32'(cause_a), 32'd1);
    tick();
    chk("ar_lu_end_a",  32'(stall_a), 32'd0);
    chk("ar_lu_perf_a", 32'(perf_a),  32'd1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
